ex_mem_stage_buf: RTL and testbench

- Parametrised EX/MEM pipeline boundary with valid/ready flow control and a 2-entry skid buffer (output register + skid register).
- Lets MEM back-pressure EX without a combinational ready path, and supports flushing on branch redirect.
- Control enables are gated by valid, so bubbles never write the register file or memory.
- Also resolves branch-taken for the front end and counts output bubble cycles for performance monitoring.

---
 rtl/ex_mem_stage_buf.sv | 146 ++++++++++++++
 tb/tb_ex_mem_stage_buf.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_buf.sv
// EX/MEM pipeline boundary: valid/ready handshake with a two-entry skid buffer
// (output register O plus skid register S), flush on redirect, valid-gated
// write enables, branch-taken resolve and a saturating output-bubble counter.
module ex_mem_stage_buf #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned BUBBLE_CNT_W = 16
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    FLUSH,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic                    RegWriteEN_In,
  input  logic                    Mem2RegSEL_In,
  input  logic                    MemWriteEN_In,
  input  logic                    Beq_In,
  input  logic                    Bne_In,
  input  logic                    ZeroFlag_In,
  input  logic [DATA_W-1:0]       ALUResult_In,
  input  logic [DATA_W-1:0]       WriteData_In,
  input  logic [DATA_W-1:0]       PC_In,
  input  logic [REG_ADDR_W-1:0]   WriteBackRegAddr_In,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic                    RegWriteEN_Out,
  output logic                    Mem2RegSEL_Out,
  output logic                    MemWriteEN_Out,
  output logic                    Beq_Out,
  output logic                    Bne_Out,
  output logic                    ZeroFlag_Out,
  output logic [DATA_W-1:0]       ALUResult_Out,
  output logic [DATA_W-1:0]       WriteData_Out,
  output logic [DATA_W-1:0]       PC_Out,
  output logic [REG_ADDR_W-1:0]   WriteBackRegAddr_Out,
  output logic                    BranchTaken_Out,
  output logic [BUBBLE_CNT_W-1:0] BubbleCount
);

  typedef struct packed {
    logic                  reg_write;
    logic                  mem2reg;
    logic                  mem_write;
    logic                  beq;
    logic                  bne;
    logic                  zero;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     write_data;
    logic [DATA_W-1:0]     pc;
    logic [REG_ADDR_W-1:0] wb_addr;
  } entry_t;

  localparam logic [BUBBLE_CNT_W-1:0] CNT_MAX = '1;

  entry_t                  o_q, o_d;
  entry_t                  s_q, s_d;
  logic                    ov_q, ov_d;
  logic                    sv_q, sv_d;
  logic [BUBBLE_CNT_W-1:0] cnt_q, cnt_d;
  entry_t                  in_entry;
  logic                    acc;
  logic                    drain;

  // Pack the EX-side fields into one entry.
  always_comb begin
    in_entry            = '0;
    in_entry.reg_write  = RegWriteEN_In;
    in_entry.mem2reg    = Mem2RegSEL_In;
    in_entry.mem_write  = MemWriteEN_In;
    in_entry.beq        = Beq_In;
    in_entry.bne        = Bne_In;
    in_entry.zero       = ZeroFlag_In;
    in_entry.alu_result = ALUResult_In;
    in_entry.write_data = WriteData_In;
    in_entry.pc         = PC_In;
    in_entry.wb_addr    = WriteBackRegAddr_In;
  end

  // Next-state for the two-entry buffer and the bubble counter.
  always_comb begin
    o_d   = o_q;
    s_d   = s_q;
    ov_d  = ov_q;
    sv_d  = sv_q;
    cnt_d = cnt_q;
    acc   = IN_VALID & ~sv_q;
    drain = ov_q & OUT_READY;

    if (!ov_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + BUBBLE_CNT_W'(1);
    end

    if (FLUSH) begin
      // Data fields are left as-is; only the valids matter after a flush.
      ov_d = 1'b0;
      sv_d = 1'b0;
    end else if (sv_q) begin
      if (drain) begin
        o_d  = s_q;
        sv_d = 1'b0;
      end
    end else if (!ov_q || drain) begin
      if (acc) begin
        o_d = in_entry;
      end
      ov_d = acc;
    end else if (acc) begin
      s_d  = in_entry;
      sv_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      o_q   <= '0;
      s_q   <= '0;
      ov_q  <= 1'b0;
      sv_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      o_q   <= o_d;
      s_q   <= s_d;
      ov_q  <= ov_d;
      sv_q  <= sv_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs are taken straight from flops; enables are gated by valid.
  assign IN_READY             = ~sv_q;
  assign OUT_VALID            = ov_q;
  assign RegWriteEN_Out       = ov_q & o_q.reg_write;
  assign MemWriteEN_Out       = ov_q & o_q.mem_write;
  assign Mem2RegSEL_Out       = o_q.mem2reg;
  assign Beq_Out              = o_q.beq;
  assign Bne_Out              = o_q.bne;
  assign ZeroFlag_Out         = o_q.zero;
  assign ALUResult_Out        = o_q.alu_result;
  assign WriteData_Out        = o_q.write_data;
  assign PC_Out               = o_q.pc;
  assign WriteBackRegAddr_Out = o_q.wb_addr;
  assign BranchTaken_Out      = ov_q & ((o_q.beq & o_q.zero) | (o_q.bne & ~o_q.zero));
  assign BubbleCount          = cnt_q;

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Scoreboard bench for ex_mem_stage_buf: a FIFO-level reference updated at
// each posedge, a monitor comparing DUT outputs at each negedge, and directed
// stimulus covering reset, pass-through, back-pressure, flush and branches.
module tb_ex_mem_stage_buf;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 3;

  typedef struct {
    logic          rw, m2r, mw, beq, bne, z, bt;
    logic [DW-1:0] alu, wd, pc;
    logic [AW-1:0] wb;
  } ent_t;

  logic          CLOCK, RESET, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic          RegWriteEN_Out, Mem2RegSEL_Out, MemWriteEN_Out;
  logic          Beq_Out, Bne_Out, ZeroFlag_Out, BranchTaken_Out;
  logic [DW-1:0] ALUResult_Out, WriteData_Out, PC_Out;
  logic [AW-1:0] WriteBackRegAddr_Out;
  logic [CW-1:0] BubbleCount;

  ent_t        stim;
  ent_t        exp_q[$];
  int unsigned exp_bc;
  int          n_cmp;
  int          n_fail;
  bit          chk_en;

  ex_mem_stage_buf #(.DATA_W(DW), .REG_ADDR_W(AW), .BUBBLE_CNT_W(CW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .RegWriteEN_In(stim.rw), .Mem2RegSEL_In(stim.m2r), .MemWriteEN_In(stim.mw),
    .Beq_In(stim.beq), .Bne_In(stim.bne), .ZeroFlag_In(stim.z),
    .ALUResult_In(stim.alu), .WriteData_In(stim.wd), .PC_In(stim.pc),
    .WriteBackRegAddr_In(stim.wb),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RegWriteEN_Out(RegWriteEN_Out), .MemWriteEN_Out(MemWriteEN_Out),
    .Mem2RegSEL_Out(Mem2RegSEL_Out), .Beq_Out(Beq_Out), .Bne_Out(Bne_Out),
    .ZeroFlag_Out(ZeroFlag_Out), .ALUResult_Out(ALUResult_Out),
    .WriteData_Out(WriteData_Out), .PC_Out(PC_Out),
    .WriteBackRegAddr_Out(WriteBackRegAddr_Out),
    .BranchTaken_Out(BranchTaken_Out), .BubbleCount(BubbleCount)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                              input logic [DW-1:0] pc, input logic [AW-1:0] wb,
                              input logic rw, input logic m2r, input logic mw,
                              input logic beq, input logic bne, input logic z,
                              input logic bt);
    ent_t e;
    e.alu = alu; e.wd = wd; e.pc = pc; e.wb = wb;
    e.rw = rw; e.m2r = m2r; e.mw = mw;
    e.beq = beq; e.bne = bne; e.z = z; e.bt = bt;
    return e;
  endfunction

  // Reference: FIFO of at most two entries plus the saturating bubble count.
  always @(posedge CLOCK) begin : model
    int sz;
    bit acc;
    sz = exp_q.size();
    if (RESET) begin
      exp_q.delete();
      exp_bc = 0;
    end else begin
      if (sz == 0 && exp_bc < 7) exp_bc++;
      if (FLUSH) begin
        exp_q.delete();
      end else begin
        acc = IN_VALID && (sz < 2);
        if (sz > 0 && OUT_READY) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(stim);
      end
    end
  end

  // Monitor: compare what the DUT presents against the head of the scoreboard.
  always @(negedge CLOCK) begin : monitor
    ent_t e;
    if (chk_en) begin
      chk("out_valid", 32'(OUT_VALID), 32'(exp_q.size() > 0));
      chk("in_ready", 32'(IN_READY), 32'(exp_q.size() < 2));
      chk("bubble_count", 32'(BubbleCount), exp_bc);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        chk("alu_result", ALUResult_Out, e.alu);
        chk("write_data", WriteData_Out, e.wd);
        chk("pc", PC_Out, e.pc);
        chk("wb_addr", 32'(WriteBackRegAddr_Out), 32'(e.wb));
        chk("reg_write", 32'(RegWriteEN_Out), 32'(e.rw));
        chk("mem2reg", 32'(Mem2RegSEL_Out), 32'(e.m2r));
        chk("mem_write", 32'(MemWriteEN_Out), 32'(e.mw));
        chk("beq", 32'(Beq_Out), 32'(e.beq));
        chk("bne", 32'(Bne_Out), 32'(e.bne));
        chk("zero", 32'(ZeroFlag_Out), 32'(e.z));
        chk("branch_taken", 32'(BranchTaken_Out), 32'(e.bt));
      end else begin
        chk("idle_reg_write", 32'(RegWriteEN_Out), 32'd0);
        chk("idle_mem_write", 32'(MemWriteEN_Out), 32'd0);
        chk("idle_branch_taken", 32'(BranchTaken_Out), 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  // Present one entry and hold it until the stage accepts it (bounded).
  task automatic send(input ent_t e);
    int n;
    n = 0;
    stim = e;
    IN_VALID = 1'b1;
    while (!IN_READY && n < 50) begin
      cyc();
      n++;
    end
    if (!IN_READY) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 at %0t", $time);
    end
    cyc();
    IN_VALID = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; chk_en = 1'b0; exp_bc = 0;
    RESET = 1'b1; FLUSH = 1'b0; OUT_READY = 1'b0; IN_VALID = 1'b1;
    stim = mk(32'hdead, 32'hbeef, 32'h100, 5'd9, 1, 1, 1, 1, 0, 1, 1);

    // Reset held two cycles with IN_VALID high.
    cyc(); cyc();
    RESET = 1'b0; IN_VALID = 1'b0; chk_en = 1'b1;
    @(negedge CLOCK);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    chk("rst_alu", ALUResult_Out, 32'd0);
    chk("rst_wdata", WriteData_Out, 32'd0);
    chk("rst_pc", PC_Out, 32'd0);
    chk("rst_wb", 32'(WriteBackRegAddr_Out), 32'd0);
    chk("rst_flags", 32'({Mem2RegSEL_Out, Beq_Out, Bne_Out, ZeroFlag_Out}), 32'd0);
    chk("rst_bubble", 32'(BubbleCount), 32'd0);

    // Idle ten cycles: 3-bit counter saturates at 7.
    repeat (10) cyc();
    @(negedge CLOCK);
    chk("bubble_saturated", 32'(BubbleCount), 32'd7);
    cyc();
    chk("bubble_held", 32'(BubbleCount), 32'd7);

    // Reset again to clear the counter for the remaining traffic.
    RESET = 1'b1; cyc(); RESET = 1'b0;

    // Single pass with one-cycle latency.
    OUT_READY = 1'b1;
    send(mk(32'h10, 32'h0, 32'h40, 5'd5, 1, 0, 0, 0, 0, 0, 0));
    @(negedge CLOCK);
    chk("pass_valid", 32'(OUT_VALID), 32'd1);
    chk("pass_alu", ALUResult_Out, 32'h10);
    chk("pass_pc", PC_Out, 32'h40);
    chk("pass_rw", 32'(RegWriteEN_Out), 32'd1);
    chk("pass_wb", 32'(WriteBackRegAddr_Out), 32'd5);
    cyc();
    @(negedge CLOCK);
    chk("pass_gone", 32'(OUT_VALID), 32'd0);

    // Back-pressure: A then B stall, then drain in order.
    cyc();
    OUT_READY = 1'b0;
    send(mk(32'hA, 32'h1A, 32'h50, 5'd1, 1, 0, 0, 0, 0, 0, 0));
    send(mk(32'hB, 32'h1B, 32'h54, 5'd2, 0, 1, 1, 0, 0, 1, 0));
    @(negedge CLOCK);
    chk("bp_in_ready", 32'(IN_READY), 32'd0);
    chk("bp_head_a", ALUResult_Out, 32'hA);
    cyc(); cyc();
    OUT_READY = 1'b1;
    @(negedge CLOCK);
    chk("bp_drain_a", ALUResult_Out, 32'hA);
    cyc();
    @(negedge CLOCK);
    chk("bp_drain_b", ALUResult_Out, 32'hB);
    chk("bp_ready_back", 32'(IN_READY), 32'd1);
    cyc(); cyc();

    // Flush with both entries full and a new entry offered.
    OUT_READY = 1'b0;
    send(mk(32'hC, 32'h1C, 32'h60, 5'd3, 1, 0, 1, 0, 0, 0, 0));
    send(mk(32'hD, 32'h1D, 32'h64, 5'd4, 1, 0, 1, 0, 0, 0, 0));
    stim = mk(32'hE, 32'h1E, 32'h68, 5'd6, 1, 0, 1, 1, 0, 1, 1);
    IN_VALID = 1'b1; FLUSH = 1'b1;
    cyc();
    IN_VALID = 1'b0; FLUSH = 1'b0;
    @(negedge CLOCK);
    chk("flush_valid", 32'(OUT_VALID), 32'd0);
    chk("flush_ready", 32'(IN_READY), 32'd1);
    chk("flush_rw", 32'(RegWriteEN_Out), 32'd0);
    chk("flush_mw", 32'(MemWriteEN_Out), 32'd0);
    OUT_READY = 1'b1;
    cyc(); cyc();

    // Flush while the stage is empty discards the entry accepted that cycle.
    stim = mk(32'hF, 32'h1F, 32'h6C, 5'd7, 1, 1, 1, 0, 1, 0, 1);
    IN_VALID = 1'b1; FLUSH = 1'b1;
    cyc();
    IN_VALID = 1'b0; FLUSH = 1'b0;
    @(negedge CLOCK);
    chk("flush_empty_valid", 32'(OUT_VALID), 32'd0);
    cyc(); cyc();

    // Branch resolve cases, streamed back to back.
    send(mk(32'h0, 32'h0, 32'h80, 5'd0, 0, 0, 0, 0, 1, 1, 0));
    send(mk(32'h1, 32'h0, 32'h84, 5'd0, 0, 0, 0, 0, 1, 0, 1));
    send(mk(32'h2, 32'h0, 32'h88, 5'd0, 0, 0, 0, 1, 0, 0, 0));
    send(mk(32'h3, 32'h0, 32'h8C, 5'd0, 0, 0, 0, 1, 0, 1, 1));
    @(negedge CLOCK);
    chk("br_beq_taken", 32'(BranchTaken_Out), 32'd1);
    cyc();
    @(negedge CLOCK);
    chk("br_invalid", 32'(BranchTaken_Out), 32'd0);

    // Mixed traffic with intermittent back-pressure.
    for (int i = 0; i < 16; i++) begin
      OUT_READY = (i % 3) != 1;
      send(mk(32'(32'h200 + i), 32'(32'h300 + i), 32'(32'h1000 + 4 * i), 5'(i),
              1'(i % 2), 1'(i % 3 == 0), 1'(i % 4 == 1), 1'(i % 5 == 0), 1'(i % 5 == 2),
              1'(i % 2 == 0),
              1'(((i % 5 == 0) && (i % 2 == 0)) || ((i % 5 == 2) && (i % 2 != 0)))));
    end
    OUT_READY = 1'b1;
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
